chip8_mem_arbiter: RTL

Shares the single-port CHIP-8 system RAM (4 KiB x 8) between three requesters, one access per cycle:
- ROM/font loader (ldr): write-only.
- CPU (cpu): read/write, used by the fetch and BCD/register-store paths.
- Video/sprite fetcher (vid): read-only.

The block drives the RAM port, tags each in-flight read and routes read data back to the requester that issued it. It sits between the CPU core, the loader, the video fetcher and the RAM macro.

---
 rtl/chip8_pkg.sv | 22 ++
 rtl/chip8_rr_pick.sv | 79 +++++++
 rtl/chip8_mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_pkg
//  Description : Shared widths and requester identifiers for the CHIP-8
//                memory subsystem.
//  Revision    : 1.0  initial release
// ============================================================================
package chip8_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DATA_W = 8;

    // Requester identifier, also used as the read-return tag.
    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_NONE = 2'd0;
    localparam req_id_t REQ_CPU  = 2'd1;
    localparam req_id_t REQ_VID  = 2'd2;
    localparam req_id_t REQ_LDR  = 2'd3;

endpackage : chip8_pkg
`default_nettype wire

// File: rtl/chip8_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_rr_pick
//  Description : Two-way CPU/video round-robin picker with a bounded CPU lock.
//                The winner is purely combinational; the last-grant pointer
//                and lock counter advance only when hold_i is low (i.e. when
//                the loader is not taking the port this cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module chip8_rr_pick
    import chip8_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    hold_i,
    input  logic    cpu_req_i,
    input  logic    vid_req_i,
    input  logic    cpu_lock_i,
    output req_id_t winner_o
);

    localparam int                CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  LOCK_LIM = CNT_W'(LOCK_MAX);

    logic             last_cpu_q, last_cpu_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_lock_ok;
    req_id_t          winner;

    // Winner selection: a live, unexhausted lock keeps the CPU; otherwise
    // the requester that was not granted last wins a conflict.
    always_comb begin
        w_lock_ok = cpu_lock_i && last_cpu_q && cpu_req_i && (cnt_q < LOCK_LIM);
        winner    = REQ_NONE;
        if (cpu_req_i && vid_req_i) begin
            winner = (w_lock_ok || !last_cpu_q) ? REQ_CPU : REQ_VID;
        end else if (cpu_req_i) begin
            winner = REQ_CPU;
        end else if (vid_req_i) begin
            winner = REQ_VID;
        end
    end

    assign winner_o = winner;

    // Next pointer/counter: frozen while the loader owns the port; the
    // counter saturates at the limit until a video grant or lock release.
    always_comb begin
        last_cpu_d = last_cpu_q;
        cnt_d      = cnt_q;
        if (!hold_i) begin
            if (winner == REQ_CPU) begin
                last_cpu_d = 1'b1;
            end else if (winner == REQ_VID) begin
                last_cpu_d = 1'b0;
            end
            if (!cpu_lock_i || (winner == REQ_VID)) begin
                cnt_d = '0;
            end else if ((winner == REQ_CPU) && w_lock_ok) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pointer and counter registers; after reset the CPU counts as last.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_cpu_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            last_cpu_q <= last_cpu_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule : chip8_rr_pick
`default_nettype wire

// File: rtl/chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_mem_arbiter
//  Description : Single-port CHIP-8 RAM arbiter for loader (write-only, top
//                priority), CPU (read/write) and video (read-only). Grants are
//                combinational, the RAM port is registered one cycle after the
//                grant and read data is routed back two cycles after the grant
//                using a two-stage tag pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W   = CHIP8_ADDR_W,
    parameter int DATA_W   = CHIP8_DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    req_id_t           winner;

    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    req_id_t           tag1_q,      tag1_d;
    req_id_t           tag2_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    chip8_rr_pick #(
        .LOCK_MAX (LOCK_MAX)
    ) u_rr_pick (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (ldr_req),
        .cpu_req_i  (cpu_req),
        .vid_req_i  (vid_req),
        .cpu_lock_i (cpu_lock),
        .winner_o   (winner)
    );

    // Grants: the loader pre-empts everything, otherwise the picker decides.
    always_comb begin
        ldr_gnt = ldr_req;
        cpu_gnt = !ldr_req && (winner == REQ_CPU);
        vid_gnt = !ldr_req && (winner == REQ_VID);
    end

    // RAM port and read tag for next cycle; address/data hold when idle.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_d      = REQ_NONE;
        if (ldr_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = ldr_addr;
            mem_wdata_d = ldr_wdata;
        end else if (cpu_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            tag1_d      = cpu_we ? REQ_NONE : REQ_CPU;
        end else if (vid_gnt) begin
            mem_en_d    = 1'b1;
            mem_addr_d  = vid_addr;
            tag1_d      = REQ_VID;
        end
    end

    // RAM port registers, tag pipeline and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_q      <= REQ_NONE;
            tag2_q      <= REQ_NONE;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (vid_rvalid) begin
                vid_rdata_q <= mem_rdata;
            end
        end
    end

    // Return path: RAM data is live in the return cycle, then held.
    always_comb begin
        cpu_rvalid = (tag2_q == REQ_CPU);
        vid_rvalid = (tag2_q == REQ_VID);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule : chip8_mem_arbiter
`default_nettype wire
